instr_fetch_unit: RTL

- Fetch initiator that drives byte addresses into the program memory and collects its returned {instruction, pc}.
- The memory has 1-cycle registered read latency, so the block tracks one in-flight request and buffers returned words in a 2-entry FIFO.
- It presents instructions to decode over a valid/ready handshake.
- It accepts redirects from the branch/jump unit, flushing stale fetches and flagging misaligned targets.

---
 rtl/instr_fetch_unit_pkg.sv | 18 +
 rtl/instr_fetch_unit_fetch_fifo.sv | 56 +++++
 rtl/instr_fetch_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Instruction words are fixed 32-bit and must sit on 4-byte boundaries.
package instr_fetch_unit_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    function automatic logic is_aligned(input logic [1:0] lsbs);
        return (lsbs & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Two-entry FIFO buffering returned {instr, pc} words ahead of decode.
// Flush empties it in one cycle; storage itself is never reset.
module fetch_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [1:0]       count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_pop;

    assign do_pop = pop & (count_q != 2'd0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // A write into a full FIFO only happens alongside a pop of that same slot.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != 2'd0);
    assign head       = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch initiator: issues byte addresses to a 1-cycle program memory, buffers
// responses in a 2-entry FIFO for decode, and handles branch/jump redirects.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          OPD_WIDTH = 32,
    parameter int          PC_WIDTH  = 12,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [PC_WIDTH-1:0]    mem_addr,
    output logic                   mem_req,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    input  logic [OPD_WIDTH-1:0]   mem_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [OPD_WIDTH-1:0]   instr_pc,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   fetch_fault
);

    localparam int ENTRY_W = INSTR_WIDTH + OPD_WIDTH;

    logic [PC_WIDTH-1:0] pc_q;
    logic                inflight_q;
    fetch_state_e        state_q;
    fetch_state_e        state_d;
    logic                fault_q;

    logic [1:0]          fifo_count;
    logic                head_valid;
    logic [ENTRY_W-1:0]  head;
    logic                push;
    logic                pop;
    logic [2:0]          occ;
    logic [2:0]          occ_after;

    assign pop       = head_valid & instr_ready;
    assign push      = inflight_q & ~redirect_valid;
    assign occ       = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign occ_after = occ - {2'b00, pop};

    // Issue only when the word can be guaranteed a FIFO slot on return.
    assign mem_req  = ~rst & ~redirect_valid & ~fault_q & (occ_after < 3'd2);
    assign mem_addr = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= PC_WIDTH'(RESET_PC);
            inflight_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q       <= redirect_pc;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= mem_req;
            if (mem_req) begin
                pc_q <= pc_q + PC_WIDTH'(INSTR_BYTES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = is_aligned(redirect_pc[1:0]) ? FETCH : FAULT;
        end
    end

    always_comb begin
        fault_q = (state_q == FAULT);
    end

    fetch_fifo #(
        .WIDTH(ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .pop        (pop & ~redirect_valid),
        .din        ({mem_data, mem_pc}),
        .count      (fifo_count),
        .head_valid (head_valid),
        .head       (head)
    );

    // Unreset FIFO storage is masked so idle outputs read as zero.
    assign instr_valid = head_valid;
    assign instr       = head_valid ? head[OPD_WIDTH +: INSTR_WIDTH] : '0;
    assign instr_pc    = head_valid ? head[OPD_WIDTH-1:0] : '0;
    assign fetch_fault = fault_q;

endmodule
